// File: rtl/eth_to_book_pkg.sv
// eth_to_book_pkg: shared order-book level types, top-of-book message constants and byte selector
package eth_to_book_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] price;
        logic [63:0] shares;
    } bookLevelType;

    typedef struct packed {
        bookLevelType buy;
        bookLevelType sell;
    } bookPairType;

    localparam int         TOB_MSG_LEN  = 30;
    localparam logic [7:0] TOB_MSG_TYPE = 8'h51;

    typedef enum logic {IDLE, SEND} tobStateType;

    // byte 0 is the most significant byte of the packed message
    function automatic logic [7:0] tob_byte(input logic [TOB_MSG_LEN*8-1:0] msg, input logic [4:0] idx);
        logic [TOB_MSG_LEN*8-1:0] s;
        s = msg << (8 * idx);
        return s[TOB_MSG_LEN*8-1 -: 8];
    endfunction

endpackage

// File: rtl/tob_publisher.sv
// tob_publisher: snapshots top-of-book changes and streams them as 30-byte messages, coalescing updates
module tob_publisher
    import eth_to_book_pkg::*;
#(
    parameter logic [7:0]  MSG_TYPE = TOB_MSG_TYPE,
    parameter logic [31:0] SEQ_INIT = 32'd1
) (
    input  logic         clkIn,
    input  logic         rstBIn,
    input  bookLevelType topBuyIn,
    input  bookLevelType topSellIn,
    output logic [7:0]   dataOut,
    output logic         dataValidOut,
    output logic         dataLastOut,
    input  logic         readyIn,
    output logic [31:0]  seqNumOut,
    output logic [15:0]  coalescedCntOut
);

    localparam logic [4:0] LAST_IDX = 5'(TOB_MSG_LEN - 1);

    tobStateType              state_q, state_d;
    bookPairType              smp_q, smp_d;
    bookPairType              smp_prev_q, smp_prev_d;
    bookPairType              pub_q, pub_d;
    logic [4:0]               idx_q, idx_d, idx_nxt;
    logic [31:0]              seq_q, seq_d;
    logic                     first_q, first_d;
    logic [15:0]              coal_q, coal_d;
    logic [7:0]               data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [TOB_MSG_LEN*8-1:0] msg;

    assign msg = {MSG_TYPE, seq_q, 6'b0, pub_q.buy.valid, pub_q.sell.valid,
                  pub_q.buy.price, pub_q.buy.shares, pub_q.sell.price, pub_q.sell.shares};
    assign idx_nxt = idx_q + 5'd1;

    assign dataOut         = data_q;
    assign dataValidOut    = valid_q;
    assign dataLastOut     = last_q;
    assign seqNumOut       = seq_q;
    assign coalescedCntOut = coal_q;

    // next-state: sample inputs, start a message on change, step bytes on handshake, count lost updates
    always_comb begin
        smp_d      = {topBuyIn, topSellIn};
        smp_prev_d = smp_q;
        pub_d      = pub_q;
        state_d    = state_q;
        idx_d      = idx_q;
        seq_d      = seq_q;
        first_d    = first_q;
        coal_d     = coal_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        if (state_q == IDLE) begin
            if (smp_q != pub_q) begin
                state_d = SEND;
                pub_d   = smp_q;
                idx_d   = 5'd0;
                seq_d   = first_q ? SEQ_INIT : seq_q + 32'd1;
                first_d = 1'b0;
                data_d  = MSG_TYPE;
                valid_d = 1'b1;
                last_d  = 1'b0;
            end
        end else begin
            if (smp_q != smp_prev_q && smp_prev_q != pub_q && coal_q != 16'hFFFF)
                coal_d = coal_q + 16'd1;
            if (valid_q && readyIn) begin
                if (last_q) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    idx_d  = idx_nxt;
                    data_d = tob_byte(msg, idx_nxt);
                    last_d = idx_nxt == LAST_IDX;
                end
            end
        end
    end

    // state and output registers, cleared asynchronously so a reset aborts any message in flight
    always_ff @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            state_q    <= IDLE;
            smp_q      <= '0;
            smp_prev_q <= '0;
            pub_q      <= '0;
            idx_q      <= '0;
            seq_q      <= '0;
            first_q    <= 1'b1;
            coal_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            smp_prev_q <= smp_prev_d;
            pub_q      <= pub_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            first_q    <= first_d;
            coal_q     <= coal_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

endmodule

// File: tb/tb_tob_publisher.sv
// tb_tob_publisher: table, directed and randomized checks of tob_publisher against a message-level model
module tb_tob_publisher;
    import eth_to_book_pkg::*;

    typedef struct packed { bookLevelType buy; bookLevelType sell; } pair_t;
    typedef struct { pair_t in; logic [31:0] seq; logic [7:0] flags; } vec_t;

    logic         clkIn = 1'b0;
    logic         rstBIn = 1'b0;
    logic         readyIn = 1'b1;
    bookLevelType topBuyIn = '0;
    bookLevelType topSellIn = '0;
    logic [7:0]   dataOut;
    logic         dataValidOut, dataLastOut;
    logic [31:0]  seqNumOut;
    logic [15:0]  coalescedCntOut;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b1;
    logic [7:0] got [30];
    int   got_n;

    pair_t       m_smp, m_prev, m_pub;
    bit          m_active, m_first;
    int          m_pos;
    logic [31:0] m_seq;
    logic [15:0] m_coal;

    tob_publisher dut (
        .clkIn(clkIn), .rstBIn(rstBIn), .topBuyIn(topBuyIn), .topSellIn(topSellIn),
        .dataOut(dataOut), .dataValidOut(dataValidOut), .dataLastOut(dataLastOut),
        .readyIn(readyIn), .seqNumOut(seqNumOut), .coalescedCntOut(coalescedCntOut)
    );

    always #2 clkIn = ~clkIn;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    // message-level reference: a published snapshot is sent byte by byte; lost intermediates are counted
    always @(posedge clkIn or negedge rstBIn) begin
        if (!rstBIn) begin
            m_smp <= '0; m_prev <= '0; m_pub <= '0;
            m_active <= 1'b0; m_first <= 1'b1; m_pos <= 0; m_seq <= '0; m_coal <= '0;
        end else begin
            if (m_active) begin
                if (m_smp != m_prev && m_prev != m_pub && m_coal != 16'hFFFF) m_coal <= m_coal + 16'd1;
                if (readyIn) begin
                    m_pos <= m_pos + 1;
                    if (m_pos == 29) m_active <= 1'b0;
                end
            end else if (m_smp != m_pub) begin
                m_pub    <= m_smp;
                m_seq    <= m_first ? 32'd1 : m_seq + 32'd1;
                m_first  <= 1'b0;
                m_pos    <= 0;
                m_active <= 1'b1;
            end
            m_prev <= m_smp;
            m_smp  <= {topBuyIn, topSellIn};
        end
    end

    function automatic bookLevelType lvl(logic v, logic [31:0] p, logic [63:0] s);
        return {v, p, s};
    endfunction

    function automatic vec_t mkv(pair_t p, logic [31:0] s, logic [7:0] f);
        vec_t v;
        v.in = p; v.seq = s; v.flags = f;
        return v;
    endfunction

    function automatic logic [7:0] exp_byte(pair_t p, logic [31:0] s, int i);
        logic [7:0] m [30];
        m[0] = 8'h51;
        m[5] = {6'b0, p.buy.valid, p.sell.valid};
        for (int k = 0; k < 4; k++) begin
            m[1+k]  = s[31-8*k -: 8];
            m[6+k]  = p.buy.price[31-8*k -: 8];
            m[18+k] = p.sell.price[31-8*k -: 8];
        end
        for (int k = 0; k < 8; k++) begin
            m[10+k] = p.buy.shares[63-8*k -: 8];
            m[22+k] = p.sell.shares[63-8*k -: 8];
        end
        return m[i];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clkIn);
        if (chk_en) begin
            chk("mon_valid", dataValidOut, m_active);
            chk("mon_last", dataLastOut, m_active && m_pos == 29);
            chk("mon_seq", seqNumOut, m_seq);
            chk("mon_coal", coalescedCntOut, m_coal);
            if (m_active) chk("mon_data", dataOut, exp_byte(m_pub, m_seq, m_pos));
        end
    endtask

    task automatic drive(pair_t p);
        topBuyIn  = p.buy;
        topSellIn = p.sell;
    endtask

    task automatic collect(input int mode);
        logic r;
        logic stall = 1'b0;
        logic [7:0] pd = '0;
        int t = 0;
        got_n = 0;
        while (got_n < 30 && t < 400) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 3 == 0) : ($urandom_range(0, 1) == 1);
            if (stall) chk("bp_hold", {dataValidOut, dataOut}, {1'b1, pd});
            readyIn = r;
            if (dataValidOut && r) begin
                got[got_n] = dataOut;
                chk("last_flag", dataLastOut, got_n == 29);
                got_n++;
            end
            stall = dataValidOut && !r;
            pd = dataOut;
            tick();
            t++;
        end
        chk("msg_len", got_n, 30);
        readyIn = 1'b1;
    endtask

    task automatic chk_msg(pair_t p, logic [31:0] s, string nm);
        for (int i = 0; i < 30; i++) chk(nm, got[i], exp_byte(p, s, i));
    endtask

    task automatic drain();
        int t = 0;
        while (dataValidOut && t < 200) begin
            tick();
            t++;
        end
        chk("drain", dataValidOut, 0);
    endtask

    task automatic reset_pulse();
        #1 rstBIn = 1'b0;
        tick();
        tick();
        rstBIn = 1'b1;
    endtask

    initial begin
        vec_t  tab [5];
        pair_t a, b_s, x, y, z, p, q, zero;
        pair_t pool [4];
        logic  seen;
        zero = '0;
        tab[0] = mkv({lvl(1'b1, 32'd1000, 64'd50), lvl(1'b0, 32'd0, 64'd0)}, 32'd1, 8'h02);
        tab[1] = mkv({lvl(1'b1, 32'd1000, 64'd50), lvl(1'b1, 32'd1010, 64'd70)}, 32'd2, 8'h03);
        tab[2] = mkv({lvl(1'b0, 32'd0, 64'd0), lvl(1'b1, 32'd1010, 64'd70)}, 32'd3, 8'h01);
        tab[3] = mkv({lvl(1'b1, 32'hDEADBEEF, 64'h0123456789ABCDEF),
                      lvl(1'b1, 32'h80000000, 64'hFFFFFFFFFFFFFFFF)}, 32'd4, 8'h03);
        tab[4] = mkv(zero, 32'd5, 8'h00);

        tick();
        tick();
        chk("rst_data", dataOut, 0);
        chk("rst_valid", dataValidOut, 0);
        chk("rst_last", dataLastOut, 0);
        chk("rst_seq", seqNumOut, 0);
        chk("rst_coal", coalescedCntOut, 0);
        rstBIn = 1'b1;
        tick();

        for (int e = 0; e < 5; e++) begin
            drive(tab[e].in);
            tick();
            chk("lat_k", dataValidOut, 0);
            tick();
            chk("lat_k1", dataValidOut, 1);
            chk("seq_out", seqNumOut, tab[e].seq);
            collect(0);
            chk("tab_seq", {got[1], got[2], got[3], got[4]}, tab[e].seq);
            chk("tab_flags", got[5], tab[e].flags);
            chk_msg(tab[e].in, tab[e].seq, "tab_byte");
        end

        p = {lvl(1'b1, 32'd2000, 64'd7), lvl(1'b1, 32'd2001, 64'd8)};
        drive(p);
        tick();
        tick();
        collect(1);
        chk_msg(p, 32'd6, "bp_byte");
        chk("bp_seq", seqNumOut, 6);

        drive(zero);
        reset_pulse();
        a = {lvl(1'b1, 32'd1000, 64'd50), lvl(1'b0, 32'd0, 64'd0)};
        drive(a);
        tick();
        tick();
        for (int k = 1; k <= 3; k++) begin
            a.buy.price = 32'd1000 + 32'(k);
            drive(a);
            tick();
        end
        drain();
        chk("coal_cnt", coalescedCntOut, 2);
        tick();
        chk("coal_next_valid", dataValidOut, 1);
        chk("coal_next_seq", seqNumOut, 2);
        collect(0);
        chk("coal_price", {got[6], got[7], got[8], got[9]}, 1003);
        chk_msg(a, 32'd2, "coal_byte");

        a.sell = lvl(1'b1, 32'd500, 64'd10);
        drive(a);
        tick();
        tick();
        b_s = a;
        b_s.sell = lvl(1'b1, 32'd600, 64'd11);
        drive(b_s);
        tick();
        drive(a);
        tick();
        drain();
        chk("aba_coal", coalescedCntOut, 3);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | dataValidOut;
        end
        chk("aba_nomsg", seen, 0);

        pool[0] = a; pool[1] = b_s; pool[2] = tab[3].in; pool[3] = zero;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) drive(pool[$urandom_range(0, 3)]);
            readyIn = $urandom_range(0, 3) != 0;
            tick();
        end
        readyIn = 1'b1;

        drive(zero);
        reset_pulse();
        x = {lvl(1'b1, 32'd3000, 64'd99), lvl(1'b1, 32'd3001, 64'd98)};
        drive(x);
        tick();
        tick();
        for (int i = 0; i < 12; i++) tick();
        chk("rst_at12", dataOut, exp_byte(x, 32'd1, 12));
        #1 rstBIn = 1'b0;
        #1;
        chk("rst_drop_valid", dataValidOut, 0);
        chk("rst_drop_seq", seqNumOut, 0);
        tick();
        tick();
        rstBIn = 1'b1;
        tick();
        chk("rst_no_trail", dataValidOut, 0);
        tick();
        chk("rst_repub_valid", dataValidOut, 1);
        chk("rst_repub_seq", seqNumOut, 1);
        collect(0);
        chk_msg(x, 32'd1, "rst_byte");

        chk_en = 1'b0;
        force dut.seq_q = 32'hFFFFFFFF;
        tick();
        tick();
        release dut.seq_q;
        y = x;
        y.buy.price = 32'd3100;
        drive(y);
        tick();
        tick();
        chk("wrap_seq", seqNumOut, 0);
        collect(0);
        chk_msg(y, 32'd0, "wrap_byte");

        z = y;
        z.sell.price = 32'd4000;
        p = z; p.buy.shares = 64'd1;
        q = z; q.buy.shares = 64'd2;
        readyIn = 1'b0;
        drive(z);
        tick();
        tick();
        for (int i = 0; i < 66000; i++) begin
            drive((i % 2 == 0) ? p : q);
            tick();
            if (i == 1000) chk("coal_1000", coalescedCntOut, 999);
            if (i == 65535) chk("coal_fffe", coalescedCntOut, 16'hFFFE);
            if (i == 65536) chk("coal_ffff", coalescedCntOut, 16'hFFFF);
        end
        chk("coal_sat", coalescedCntOut, 16'hFFFF);
        chk("stall_valid", dataValidOut, 1);
        drive(z);
        readyIn = 1'b1;
        drain();
        chk("coal_sat_end", coalescedCntOut, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
